// File: rtl/resp_collector.sv
// -----------------------------------------------------------------------------
// resp_collector
//   Buffers a push-only response stream in a DEPTH-entry circular FIFO.
//   Presents the buffered words to a sink over a valid/ready handshake.
//   Keeps overflow and receive/drop statistics.
//
// Ports
//   clk_i, rstn_i            clock (rising edge), async active-low reset
//   in_valid_i, in_data_i    push stream; it has no backpressure
//   out_valid_o, out_data_o  FIFO head; it is popped when out_ready_i=1
//   out_ready_i              sink accepts the head
//   level_o                  current occupancy
//   almost_full_o            level_o >= AFULL_LVL
//   overflow_o               sticky flag: at least one word was dropped
//   rx_cnt_o                 accepted words; wraps
//   drop_cnt_o               dropped words; saturates
//   clr_i                    synchronous clear of overflow_o, rx_cnt_o and drop_cnt_o
// -----------------------------------------------------------------------------
module resp_collector #(
  parameter int DATA_SIZE = 16,
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = 3,
  parameter int CNT_W     = 8,
  localparam int LVL_W    = $clog2(DEPTH + 1),
  localparam int PTR_W    = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 in_valid_i,
  input  logic [DATA_SIZE-1:0] in_data_i,
  output logic                 out_valid_o,
  output logic [DATA_SIZE-1:0] out_data_o,
  input  logic                 out_ready_i,
  output logic [LVL_W-1:0]     level_o,
  output logic                 almost_full_o,
  output logic                 overflow_o,
  output logic [CNT_W-1:0]     rx_cnt_o,
  output logic [CNT_W-1:0]     drop_cnt_o,
  input  logic                 clr_i
);

  logic [DATA_SIZE-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]     level_q;
  logic                 overflow_q;
  logic [CNT_W-1:0]     rx_cnt_q, drop_cnt_q;

  logic full, push, pop, accept, drop;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    full   = 1'b0;
    push   = 1'b0;
    pop    = 1'b0;
    accept = 1'b0;
    drop   = 1'b0;
    full   = (level_q == LVL_W'(DEPTH));
    push   = in_valid_i;
    pop    = (level_q != '0) && out_ready_i;
    // A full FIFO can still take a word when the head leaves in the same cycle.
    accept = push && (!full || pop);
    drop   = push && full && !pop;
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    // The wrap is explicit so that DEPTH does not have to be a power of 2.
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: the storage is reset too. This keeps out_data_o defined (never X)
  //       while the FIFO is empty after reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only. All flops then
      //       sample values from before the edge, with no ordering races.
      if (accept) begin
        mem_q[wr_ptr_q] <= in_data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (accept && !pop)      level_q <= level_q + 1'b1;
      else if (pop && !accept) level_q <= level_q - 1'b1;
    end
  end

  // Statistics: clr_i wins over any push or drop in the same cycle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      overflow_q <= 1'b0;
      rx_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else if (clr_i) begin
      overflow_q <= 1'b0;
      rx_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (accept) rx_cnt_q <= rx_cnt_q + 1'b1;
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
      end
    end
  end

  // Every output is a register or is decoded from registers only.
  assign out_valid_o   = (level_q != '0);
  assign out_data_o    = mem_q[rd_ptr_q];
  assign level_o       = level_q;
  assign almost_full_o = (level_q >= LVL_W'(AFULL_LVL));
  assign overflow_o    = overflow_q;
  assign rx_cnt_o      = rx_cnt_q;
  assign drop_cnt_o    = drop_cnt_q;

endmodule
